// File: rtl/ebpf_regfile_sb.sv
// eBPF register file: NUM_RD combinational read ports with write bypass, ALU and
// load-return write ports, a per-register load scoreboard and a registered exception code.

module ebpf_regfile_rdport #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 11,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]                 idx,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              pending,
  input  logic                             wb_acc,
  input  logic [IDX_W-1:0]                 wb_idx,
  input  logic [DATA_W-1:0]                wb_data,
  input  logic                             wa_acc,
  input  logic [IDX_W-1:0]                 wa_idx,
  input  logic [DATA_W-1:0]                wa_val,
  output logic [DATA_W-1:0]                data,
  output logic                             hazard,
  output logic                             invalid
);
  always_comb begin
    data    = '0;
    hazard  = 1'b0;
    invalid = 1'b0;
    if (int'(idx) >= NUM_REGS) begin
      invalid = 1'b1;
    end else begin
      // a load returning this cycle both supplies the data and clears the hazard
      hazard = pending[idx] && !(wb_acc && wb_idx == idx);
      if (wb_acc && wb_idx == idx)      data = wb_data;
      else if (wa_acc && wa_idx == idx) data = wa_val;
      else                              data = regs[idx];
    end
  end
endmodule

module ebpf_regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 11,
  parameter int RO_REGS  = 1,
  parameter int NUM_RD   = 2,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sp_load,
  input  logic [DATA_W-1:0]          sp_init,
  input  logic [NUM_RD*IDX_W-1:0]    rd_idx,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_hazard,
  input  logic                       wa_en,
  input  logic [IDX_W-1:0]           wa_idx,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wa_alu32,
  input  logic                       ld_issue,
  input  logic [IDX_W-1:0]           ld_idx,
  input  logic                       wb_en,
  input  logic [IDX_W-1:0]           wb_idx,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [NUM_REGS-1:0]        pending,
  output logic [1:0]                 exc
);
  localparam int WR_N = NUM_REGS - RO_REGS;
  localparam logic [1:0] EXC_NONE = 2'd0, EXC_INV_DST = 2'd1,
                         EXC_INV_SRC = 2'd2, EXC_PEND_DST = 2'd3;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             pend_q;
  logic [DATA_W-1:0]               lo32_mask, wa_val;
  logic                            wa_wr, ld_wr, wb_wr;
  logic                            wa_pend, ld_pend, wb_pend;
  logic                            wa_acc, ld_acc, wb_acc, wb_ld_same;
  logic                            inv_dst, inv_src, pend_dst;
  logic [NUM_RD-1:0]               rd_inv;

  function automatic logic pend_of(input logic [NUM_REGS-1:0] p, input logic [IDX_W-1:0] i);
    return (int'(i) < NUM_REGS) ? p[i] : 1'b0;
  endfunction

  assign pending = pend_q;

  always_comb begin
    lo32_mask = '0;
    for (int b = 0; b < DATA_W; b++) lo32_mask[b] = (b < 32);
  end

  assign wa_val = wa_alu32 ? (wa_data & lo32_mask) : wa_data;

  assign wa_wr   = int'(wa_idx) < WR_N;
  assign ld_wr   = int'(ld_idx) < WR_N;
  assign wb_wr   = int'(wb_idx) < WR_N;
  assign wa_pend = pend_of(pend_q, wa_idx);
  assign ld_pend = pend_of(pend_q, ld_idx);
  assign wb_pend = pend_of(pend_q, wb_idx);

  assign wb_acc     = wb_en && wb_wr && wb_pend;
  assign wa_acc     = wa_en && wa_wr && !wa_pend;
  assign wb_ld_same = wb_acc && (wb_idx == ld_idx);
  // a load issued to a register whose previous load returns this cycle re-arms it
  assign ld_acc     = ld_issue && ld_wr && (!ld_pend || wb_ld_same);

  assign inv_dst  = (wa_en && !wa_wr) || (ld_issue && !ld_wr) || (wb_en && !wb_acc);
  assign inv_src  = |rd_inv;
  assign pend_dst = (wa_en && wa_wr && wa_pend) || (ld_issue && ld_wr && ld_pend && !wb_ld_same);

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    ebpf_regfile_rdport #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rd (
      .idx     (rd_idx[g*IDX_W +: IDX_W]),
      .regs    (regs),
      .pending (pend_q),
      .wb_acc  (wb_acc),
      .wb_idx  (wb_idx),
      .wb_data (wb_data),
      .wa_acc  (wa_acc),
      .wa_idx  (wa_idx),
      .wa_val  (wa_val),
      .data    (rd_data[g*DATA_W +: DATA_W]),
      .hazard  (rd_hazard[g]),
      .invalid (rd_inv[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs   <= '0;
      pend_q <= '0;
      exc    <= EXC_NONE;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (sp_load && r == NUM_REGS-1)          regs[r] <= sp_init;
        else if (wb_acc && int'(wb_idx) == r)    regs[r] <= wb_data;
        else if (wa_acc && int'(wa_idx) == r)    regs[r] <= wa_val;
        pend_q[r] <= (pend_q[r] && !(wb_acc && int'(wb_idx) == r)) ||
                     (ld_acc && int'(ld_idx) == r);
      end
      if (inv_dst)       exc <= EXC_INV_DST;
      else if (inv_src)  exc <= EXC_INV_SRC;
      else if (pend_dst) exc <= EXC_PEND_DST;
      else               exc <= EXC_NONE;
    end
  end
endmodule

// File: tb/tb_ebpf_regfile_sb.sv
// Scoreboard bench for ebpf_regfile_sb: expectations queued at stimulus, popped at observation.

module tb_ebpf_regfile_sb;
  logic         clk = 1'b0;
  logic         reset;
  logic         sp_load;
  logic [63:0]  sp_init;
  logic [7:0]   rd_idx;
  logic [127:0] rd_data;
  logic [1:0]   rd_hazard;
  logic         wa_en, wa_alu32, ld_issue, wb_en;
  logic [3:0]   wa_idx, ld_idx, wb_idx;
  logic [63:0]  wa_data, wb_data;
  logic [10:0]  pending;
  logic [1:0]   exc;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  always #5 clk = ~clk;

  ebpf_regfile_sb dut (
    .clk(clk), .reset(reset), .sp_load(sp_load), .sp_init(sp_init),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_hazard(rd_hazard),
    .wa_en(wa_en), .wa_idx(wa_idx), .wa_data(wa_data), .wa_alu32(wa_alu32),
    .ld_issue(ld_issue), .ld_idx(ld_idx),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .pending(pending), .exc(exc)
  );

  task automatic idle();
    sp_load = 0; sp_init = '0; rd_idx = '0;
    wa_en = 0; wa_idx = '0; wa_data = '0; wa_alu32 = 0;
    ld_issue = 0; ld_idx = '0; wb_en = 0; wb_idx = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.push_back(64'd0); e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL reset_exc got %0d want %0d", exc, e); end
    exp_q.push_back(64'd0); e = exp_q.pop_front(); checks++;
    if ({53'd0, pending} !== e) begin errors++; $display("FAIL reset_pending got %h want %h", pending, e); end
    for (int i = 0; i < 10; i++) begin
      rd_idx = {4'd0, 4'(i)};
      exp_q.push_back(64'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd_data[63:0] !== e) begin errors++; $display("FAIL reset_r%0d got %h want %h", i, rd_data[63:0], e); end
    end
    @(negedge clk);
    sp_load = 1; sp_init = 64'h1000; exp_q.push_back(64'h1000);
    @(negedge clk);
    idle(); rd_idx = {4'd0, 4'd10};
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL sp_load got %h want %h", rd_data[63:0], e); end
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    wa_en = 1; wa_idx = 4'd3; wa_data = 64'hFFFF_FFFF_1234_5678; wa_alu32 = 1;
    rd_idx = {4'd0, 4'd3};
    exp_q.push_back(64'h0000_0000_1234_5678);
    exp_q.push_back(64'h0000_0000_1234_5678);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL alu32_bypass got %h want %h", rd_data[63:0], e); end
    @(negedge clk);
    wa_en = 1; wa_idx = 4'd5; wa_data = 64'hDEAD_BEEF_CAFE_F00D; wa_alu32 = 0;
    rd_idx = {4'd5, 4'd3};
    exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL alu32_stored got %h want %h", rd_data[63:0], e); end
    e = exp_q.pop_front(); checks++;
    if (rd_data[127:64] !== e) begin errors++; $display("FAIL alu64_bypass_p1 got %h want %h", rd_data[127:64], e); end
    @(negedge clk);
    idle(); rd_idx = {4'd5, 4'd0};
    exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[127:64] !== e) begin errors++; $display("FAIL alu64_stored got %h want %h", rd_data[127:64], e); end
    e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL alu_exc got %0d want %0d", exc, e); end
  endtask

  task automatic test_load();
    @(negedge clk);
    ld_issue = 1; ld_idx = 4'd2;
    @(negedge clk);
    idle(); rd_idx = {4'd0, 4'd2};
    exp_q.push_back(64'd1); exp_q.push_back(64'h4);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({63'd0, rd_hazard[0]} !== e) begin errors++; $display("FAIL load_hazard got %0d want %0d", rd_hazard[0], e); end
    e = exp_q.pop_front(); checks++;
    if ({53'd0, pending} !== e) begin errors++; $display("FAIL load_pending got %h want %h", pending, e); end
    @(negedge clk);
    wb_en = 1; wb_idx = 4'd2; wb_data = 64'hAB;
    exp_q.push_back(64'hAB); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL wb_bypass got %h want %h", rd_data[63:0], e); end
    e = exp_q.pop_front(); checks++;
    if ({63'd0, rd_hazard[0]} !== e) begin errors++; $display("FAIL wb_hazard got %0d want %0d", rd_hazard[0], e); end
    @(negedge clk);
    idle(); rd_idx = {4'd0, 4'd2};
    exp_q.push_back(64'd0); exp_q.push_back(64'hAB);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({53'd0, pending} !== e) begin errors++; $display("FAIL wb_pending got %h want %h", pending, e); end
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL wb_stored got %h want %h", rd_data[63:0], e); end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    wa_en = 1; wa_idx = 4'd10; wa_data = 64'd5;
    exp_q.push_back(64'd1); exp_q.push_back(64'h1000);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL ro_write_exc got %0d want %0d", exc, e); end
    @(negedge clk);
    idle(); rd_idx = {4'd0, 4'd10};
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL ro_unchanged got %h want %h", rd_data[63:0], e); end
    @(negedge clk);
    rd_idx = {4'd0, 4'd11};
    exp_q.push_back(64'd0); exp_q.push_back(64'd2); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL oob_read got %h want %h", rd_data[63:0], e); end
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL oob_exc got %0d want %0d", exc, e); end
    @(negedge clk);
    rd_idx = '0;
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL exc_not_sticky got %0d want %0d", exc, e); end
  endtask

  task automatic test_pending_dst();
    @(negedge clk);
    idle(); ld_issue = 1; ld_idx = 4'd4;
    @(negedge clk);
    idle(); wa_en = 1; wa_idx = 4'd4; wa_data = 64'd7; rd_idx = {4'd0, 4'd4};
    exp_q.push_back(64'd3); exp_q.push_back(64'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL waw_exc got %0d want %0d", exc, e); end
    @(negedge clk);
    idle(); rd_idx = {4'd0, 4'd4};
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL waw_unchanged got %h want %h", rd_data[63:0], e); end
    @(negedge clk);
    ld_issue = 1; ld_idx = 4'd4; wb_en = 1; wb_idx = 4'd4; wb_data = 64'd9;
    exp_q.push_back(64'd9); exp_q.push_back(64'd1); exp_q.push_back(64'd0);
    @(negedge clk);
    idle(); rd_idx = {4'd0, 4'd4};
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL ld_wb_data got %h want %h", rd_data[63:0], e); end
    e = exp_q.pop_front(); checks++;
    if ({63'd0, pending[4]} !== e) begin errors++; $display("FAIL ld_wb_pending got %0d want %0d", pending[4], e); end
    e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL ld_wb_exc got %0d want %0d", exc, e); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle(); wb_en = 1; wb_idx = 4'd4; wb_data = 64'h44;
    ld_issue = 1; ld_idx = 4'd6;
    @(negedge clk);
    idle();
    wa_en = 1; wa_idx = 4'd7; wa_data = 64'h77;
    wb_en = 1; wb_idx = 4'd6; wb_data = 64'h66;
    exp_q.push_back(64'h66); exp_q.push_back(64'h77); exp_q.push_back(64'd0);
    @(negedge clk);
    idle(); rd_idx = {4'd7, 4'd6};
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL dual_wb got %h want %h", rd_data[63:0], e); end
    e = exp_q.pop_front(); checks++;
    if (rd_data[127:64] !== e) begin errors++; $display("FAIL dual_wa got %h want %h", rd_data[127:64], e); end
    e = exp_q.pop_front(); checks++;
    if ({53'd0, pending} !== e) begin errors++; $display("FAIL dual_pending got %h want %h", pending, e); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle(); ld_issue = 1; ld_idx = 4'd1;
    @(negedge clk);
    idle(); reset = 1'b1;
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({53'd0, pending} !== e) begin errors++; $display("FAIL midreset_pending got %h want %h", pending, e); end
    @(negedge clk);
    reset = 1'b0;
    wb_en = 1; wb_idx = 4'd1; wb_data = 64'd3; rd_idx = {4'd0, 4'd1};
    exp_q.push_back(64'd1); exp_q.push_back(64'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if ({62'd0, exc} !== e) begin errors++; $display("FAIL stray_wb_exc got %0d want %0d", exc, e); end
    @(negedge clk);
    idle(); rd_idx = {4'd0, 4'd1};
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[63:0] !== e) begin errors++; $display("FAIL stray_wb_data got %h want %h", rd_data[63:0], e); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load();
    test_invalid();
    test_pending_dst();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
